subtree_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one common resource slot among the NUM_REQ child instances of a generated subtree module (default 5, inst_0..inst_4).
- Each child raises a request and holds the grant until it signals done.
- The scheduler guarantees exactly one owner at a time, starvation-free rotation, and a bounded hold time (optional).
- Sits in the parent module alongside the child instances, one scheduler per parent.

---
 rtl/subtree_rr_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_subtree_rr_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtree_rr_scheduler.sv
// -----------------------------------------------------------------------------
// subtree_rr_scheduler
//
// Round-robin owner scheduler for one shared resource slot inside a parent
// module. The NUM_REQ child instances of a generated subtree raise req. The
// scheduler hands the slot to exactly one child at a time. That child keeps
// the slot until it strobes its own done bit.
//
// After owner k releases, the priority order is k+1 .. NUM_REQ-1, 0 .. k.
// Because of this order, a requester that keeps its req asserted is served
// once per NUM_REQ grants.
//
// Optional feature (compile-time macro SUBTREE_SCHED_WATCHDOG_EN):
//   A hold watchdog forces a release after MAX_HOLD cycles in GRANT.
//   timeout pulses for one cycle on a forced release.
//   Without the macro no hold counter exists, timeout is always 0 and
//   MAX_HOLD has no effect.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester level request
//   done       per-requester release strobe (only the owner's bit matters)
//   gnt        registered one-hot grant
//   gnt_id     index of the current owner (meaningful while busy=1)
//   busy       high while a grant is held
//   grant_cnt  8-bit count of issued grants, wraps 255 -> 0
//   timeout    one-cycle pulse on a watchdog-forced release
// -----------------------------------------------------------------------------
module subtree_rr_scheduler #(
  parameter int NUM_REQ  = 5,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic [7:0]         grant_cnt,
  output logic               timeout
);

  // Parameter sanity; these blocks elaborate only on a bad configuration.
  if ((NUM_REQ < 2) || (NUM_REQ > 16)) begin : g_bad_num_req
    $error("subtree_rr_scheduler: NUM_REQ must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("subtree_rr_scheduler: MAX_HOLD must be >= 2");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic [ID_W-1:0]    gnt_id_r, gnt_id_s;
  logic               busy_r, busy_s;
  logic [7:0]         cnt_r, cnt_s;
  logic               timeout_r, timeout_s;
  logic [ID_W-1:0]    last_r, last_s;

  logic               win_found_s;
  logic [ID_W-1:0]    win_id_s;
  logic [ID_W:0]      cand_s;
  logic               owner_done_s;
  logic               expire_s;

  // Rotating search: the first requester found after last_r, wrapping modulo NUM_REQ.
  // cand_s has one extra bit so that last_r + i cannot overflow before the wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = {1'b0, last_r} + (ID_W+1)'(i);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Only the current owner's done bit can release the slot.
  assign owner_done_s = done[gnt_id_r];

`ifdef SUBTREE_SCHED_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_r;

  // Hold counter: zero while idle, so it reads 0 in the first GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= '0;
    end else if (state_r == ST_IDLE) begin
      hold_r <= '0;
    end else begin
      hold_r <= hold_r + HOLD_W'(1);
    end
  end

  assign expire_s = (hold_r == HOLD_W'(MAX_HOLD - 1));
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    gnt_id_s  = gnt_id_r;
    busy_s    = busy_r;
    cnt_s     = cnt_r;
    last_s    = last_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_s  = ST_GRANT;
          gnt_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
          gnt_id_s = win_id_s;
          busy_s   = 1'b1;
          last_s   = win_id_s;
          cnt_s    = cnt_r + 8'd1;
        end else begin
          gnt_s  = '0;
          busy_s = 1'b0;
        end
      end
      ST_GRANT: begin
        // A done on the expiry edge counts as a normal release, so it is checked first.
        if (owner_done_s) begin
          state_s = ST_IDLE;
          gnt_s   = '0;
          busy_s  = 1'b0;
        end else if (expire_s) begin
          state_s   = ST_IDLE;
          gnt_s     = '0;
          busy_s    = 1'b0;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs. Reset sets last_r to NUM_REQ-1 so that requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      gnt_id_r  <= '0;
      busy_r    <= 1'b0;
      cnt_r     <= 8'd0;
      timeout_r <= 1'b0;
      last_r    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      gnt_id_r  <= gnt_id_s;
      busy_r    <= busy_s;
      cnt_r     <= cnt_s;
      timeout_r <= timeout_s;
      last_r    <= last_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign busy      = busy_r;
  assign grant_cnt = cnt_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_subtree_rr_scheduler
//
// Directed bench for subtree_rr_scheduler at NUM_REQ=5. Every expected value
// is written out by hand.
//
// Timing: inputs change 1 ns after a rising edge. Outputs are sampled at that
// same point, i.e. away from the active edge.
//
// The watchdog scenario runs when SUBTREE_SCHED_WATCHDOG_EN is defined, with
// MAX_HOLD=4. In the default build the bench instead checks that a long hold
// never times out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_subtree_rr_scheduler;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic         busy;
  logic [7:0]   grant_cnt;
  logic         timeout;

  int total_cnt;
  int bad_cnt;

  subtree_rr_scheduler #(
    .NUM_REQ  (N),
    .ID_W     (3),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .grant_cnt (grant_cnt),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_gnt;
    int order [6];
    total_cnt = 0;
    bad_cnt   = 0;
    rst  = 1'b1;
    req  = '0;
    done = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_cnt", 32'(grant_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // Single request: one-cycle latency, grant to index 2
    req = 5'b00100;
    #1;
    chk("lat_before_edge", 32'(gnt), 32'd0);
    tick();
    chk("single_gnt", 32'(gnt), 32'b00100);
    chk("single_id", 32'(gnt_id), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_cnt", 32'(grant_cnt), 32'd1);
    req  = '0;
    done = 5'b00100;
    tick();
    done = '0;
    chk("single_rel", 32'(gnt), 32'd0);
    chk("single_rel_busy", 32'(busy), 32'd0);

    // Full rotation under all-request, with an idle cycle between owners
    do_reset();
    order = '{0, 1, 2, 3, 4, 0};
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_gnt = 5'b00001 << order[k];
      chk("rot_gnt", 32'(gnt), 32'(exp_gnt));
      chk("rot_id", 32'(gnt_id), 32'(order[k]));
      done = exp_gnt;
      tick();
      done = '0;
      chk("rot_idle_gap", 32'(gnt), 32'd0);
    end
    chk("rot_cnt", 32'(grant_cnt), 32'd6);

    // Sticky grant: non-owner done and dropped req do not release
    req = 5'b00010;
    tick();
    chk("sticky_gnt", 32'(gnt), 32'b00010);
    done = 5'b01000;
    req  = '0;
    tick();
    chk("sticky_hold1", 32'(gnt), 32'b00010);
    tick();
    chk("sticky_hold2", 32'(gnt), 32'b00010);
    chk("sticky_id", 32'(gnt_id), 32'd1);
    done = 5'b00010;
    tick();
    done = '0;
    chk("sticky_rel", 32'(gnt), 32'd0);
    chk("sticky_cnt", 32'(grant_cnt), 32'd7);

    // Same-cycle done+req: another pending requester wins first
    req = 5'b00010;
    tick();
    chk("same_gnt1", 32'(gnt), 32'b00010);
    done = 5'b00010;
    req  = 5'b00110;
    tick();
    done = '0;
    chk("same_rel", 32'(gnt), 32'd0);
    tick();
    chk("same_other_wins", 32'(gnt), 32'b00100);
    // Releasing while re-requesting with nobody else pending re-grants the same requester
    req  = 5'b00100;
    done = 5'b00100;
    tick();
    done = '0;
    chk("regrant_gap", 32'(gnt), 32'd0);
    tick();
    chk("regrant_self", 32'(gnt), 32'b00100);
    chk("regrant_cnt", 32'(grant_cnt), 32'd10);
    req  = '0;
    done = 5'b00100;
    tick();
    done = '0;

    // Reset during a grant, then the pointer is back at NUM_REQ-1
    req = 5'b01000;
    tick();
    chk("mid_gnt", 32'(gnt), 32'b01000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(grant_cnt), 32'd0);
    req = 5'b11000;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'b01000);
    chk("post_rst_id", 32'(gnt_id), 32'd3);
    req  = '0;
    done = 5'b01000;
    tick();
    done = '0;

    // grant_cnt wraps after 256 grants
    do_reset();
    req = 5'b00001;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 255) begin
        chk("cnt_255", 32'(grant_cnt), 32'd255);
      end
      done = 5'b00001;
      tick();
      done = '0;
    end
    chk("cnt_wrap", 32'(grant_cnt), 32'd0);
    req = '0;
    tick();

`ifdef SUBTREE_SCHED_WATCHDOG_EN
    // Watchdog: owner 0 never releases; forced release 4 cycles after the grant
    do_reset();
    req = 5'b00011;
    tick();
    chk("wd_gnt0", 32'(gnt), 32'b00001);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("wd_hold", 32'(gnt), 32'b00001);
      chk("wd_no_to", 32'(timeout), 32'd0);
    end
    tick();
    chk("wd_drop", 32'(gnt), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_timeout", 32'(timeout), 32'd1);
    tick();
    chk("wd_timeout_once", 32'(timeout), 32'd0);
    chk("wd_next_owner", 32'(gnt), 32'b00010);
`else
    // No watchdog: a grant holds indefinitely and timeout never pulses
    do_reset();
    req = 5'b00011;
    tick();
    chk("nowd_gnt0", 32'(gnt), 32'b00001);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (timeout !== 1'b0) begin
        chk("nowd_timeout", 32'(timeout), 32'd0);
      end
    end
    chk("nowd_still_held", 32'(gnt), 32'b00001);
    chk("nowd_timeout_end", 32'(timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
